grf_wb_arbiter: RTL

//   Shares the single GRF write port (A3/WD/WrEn) between two sources:
//   - the pipeline WB stage (primary)
//   - a long-latency unit, e.g. the MDU writing to a GPR (secondary)

---
 rtl/grf_wb_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between WB (primary) and a buffered long-latency source (secondary).
// Optional same-cycle secondary bypass when idle: define GRF_ARB_BYPASS_EN.
module grf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pri_valid,
  input  logic [4:0]  pri_addr,
  input  logic [31:0] pri_data,
  output logic        pri_ready,
  input  logic        sec_valid,
  input  logic [4:0]  sec_addr,
  input  logic [31:0] sec_data,
  output logic        sec_ready,
  input  logic        claim_valid,
  input  logic [4:0]  claim_addr,
  output logic [31:0] busy_vec,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic        grf_wr_en
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;
  logic [31:0]      busy_q;
  logic [31:0]      busy_next;

  logic        fifo_empty;
  logic        fifo_has_room;
  logic        override;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign fifo_empty    = (count == '0);
  assign fifo_has_room = (count < DEPTH_C);
  assign override      = !fifo_empty && (starve_cnt >= LIMIT_C);
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];

`ifdef GRF_ARB_BYPASS_EN
  // Idle write port and empty FIFO: secondary goes straight to the GRF.
  assign bypass = reset_n && fifo_empty && !pri_valid && sec_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop       = reset_n && !fifo_empty && (override || !pri_valid);
  assign push      = reset_n && sec_valid && fifo_has_room && !bypass;
  assign sec_ready = reset_n && fifo_has_room;
  assign pri_ready = reset_n && !override;
  assign busy_vec  = busy_q;

  // Register 0 transfers complete their handshake but never assert the write enable.
  always_comb begin
    grf_wr_en = 1'b0;
    grf_a3    = '0;
    grf_wd    = '0;
    if (reset_n) begin
      if (!override && pri_valid) begin
        grf_a3    = pri_addr;
        grf_wd    = pri_data;
        grf_wr_en = (pri_addr != 5'd0);
      end else if (pop) begin
        grf_a3    = head_addr;
        grf_wd    = head_data;
        grf_wr_en = (head_addr != 5'd0);
      end else if (bypass) begin
        grf_a3    = sec_addr;
        grf_wd    = sec_data;
        grf_wr_en = (sec_addr != 5'd0);
      end
    end
  end

  // Clears first so a same-cycle claim on the same register wins.
  always_comb begin
    busy_next = busy_q;
    if (pop)
      busy_next[head_addr] = 1'b0;
    if (bypass)
      busy_next[sec_addr] = 1'b0;
    if (claim_valid)
      busy_next[claim_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sec_addr;
      fifo_data[wr_ptr] <= sec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy_q     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo_empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C)
        starve_cnt <= starve_cnt + 1'b1;
      busy_q <= busy_next;
    end
  end

endmodule
